uart_rx_deserialiser: RTL and testbench
=======================================

# uart_rx_deserialiser

Serial receive front-end for the AHB UART peripheral. It takes the asynchronous `serialRx` line, synchronises it and detects start bits with 16x oversampling. It samples 8N1 frames LSB-first at mid-bit and delivers each byte as a one-cycle strobe into the UART's receive FIFO, and it flags framing errors. It sits between the board RX pin and the AHB-facing register/FIFO logic that software reads at the RXDATA/STATUS addresses.

## Interface
Parameters:
- `TICK_DIV`, 163: `HCLK` cycles per oversample tick. 50 MHz / (19200 × 16) ≈ 163. Legal range 2..65535.
- `OVERSAMPLE`, 16: ticks per bit. Fixed; taken from the package.

Ports:
- `HCLK`  in  1  bus clock; the only clock.
- `HRESET`  in  1  reset; synchronous, active-high.
- `serialRx`  in  1  asynchronous serial input; idles high.
- `rxData`  out  8  last received byte; held until the next frame ends.
- `rxValid`  out  1  one-cycle strobe: `rxData` is a good byte.
- `frameErr`  out  1  one-cycle strobe: stop bit sampled low.
- `busy`  out  1  high while a frame is being received (any state except IDLE).

## Operation
- **Input synchroniser:** 2-flop, reset to 1. `rxS` is the second flop. `rxPrev` is a delayed copy of `rxS`, also reset to 1.
- **Tick generator:** counts 0..`TICK_DIV`-1 and pulses `tick` on the terminal count. It is cleared to 0 whenever the FSM leaves IDLE, so ticks are phase-aligned to the start edge.
- **`sampCnt` (4 bit):** counts ticks within a bit. **`bitCnt` (3 bit):** counts data bits.
- **FSM states:** IDLE, START, DATA, STOP.
- **IDLE:**
  - A falling edge (`rxPrev`=1, `rxS`=0) goes to START and clears `sampCnt`.
  - A line held low (break) never retriggers; a falling edge is required.
- **START:** on the tick where `sampCnt`=7 (mid start bit):
  - `rxS`=0: go to DATA, clear `sampCnt` and `bitCnt`.
  - `rxS`=1: glitch; return to IDLE with no output.
- **DATA:** on each tick where `sampCnt`=15:
  - Shift `rxS` into bit 7 of the shift register (LSB-first result).
  - Increment `bitCnt`; after the 8th sample go to STOP.
- **STOP:** on the tick where `sampCnt`=15 (mid stop bit):
  - `rxS`=1: load `rxData` from the shift register and pulse `rxValid`.
  - `rxS`=0: pulse `frameErr`; `rxData` is unchanged.
  - Either way, go to IDLE.
- **Mutual exclusion:** `rxValid` and `frameErr` are never high together.
- **No back-pressure:** the consumer must accept `rxValid` in the cycle it is asserted. Overrun is the consumer FIFO's concern.
- **Reset:** `HRESET` at any point, including mid-frame, returns to IDLE and resets:
  - `rxData`=0, `rxValid`=0, `frameErr`=0, `busy`=0.
  - All counters 0; synchroniser and `rxPrev` = 1.
  - A partial frame is discarded silently.

## Timing
- **Start detection:** `rxS` lags the pin by 2 cycles, and the falling edge is registered 1 cycle later.
- **Bit period:** 16 × `TICK_DIV` cycles. All samples fall at mid-bit ±1 `HCLK`.
- **Latency:** `rxValid`/`frameErr` are registered and rise 1 cycle after the mid-stop-bit tick. That is ≈ 9.5 bit periods + 4 cycles after the pin's falling start edge.
- **`busy`:** rises 1 cycle after the falling edge is detected and falls in the same cycle as the `rxValid`/`frameErr` strobe.
- **Back-to-back frames:** the FSM reaches IDLE half a bit before the stop bit ends. A start edge immediately after a 1-bit stop is therefore caught with no lost frame.
- **Baud tolerance:** ±3% between sender and receiver.

## Structure
- **Package `uart_pkg`:**
  - State enum {IDLE, START, DATA, STOP}.
  - `OVERSAMPLE`=16.
  - `MID_START`=7, `MID_BIT`=15.
  - Shared with the transmit side.
- **Sub-module `uart_baud_tick`:** parameter `TICK_DIV`; inputs `HCLK`, `HRESET`, `clr`; output `tick`. It is reused by the transmitter.
- **Rest of the block:** synchroniser, FSM, counters and shift register stay in the top module.
- **Size:** about 150 lines.

## Test plan
Benches use `TICK_DIV`=4 (bit period 64 cycles) and drive `serialRx` with a task that sends 8N1 frames.
- Send 0x65 → exactly one `rxValid`, `rxData`=0x65, `frameErr` stays 0, `busy` back to 0 in the same cycle.
- Low glitch of 20 cycles on an idle line → no `rxValid`/`frameErr`; `busy` pulses and drops after the mid-start sample.
- Send 0xA7 with stop bit forced low → one `frameErr` pulse, no `rxValid`, `rxData` keeps its previous value; line held low for 5 bit periods → no further activity until line returns high and a new frame arrives.
- Back-to-back 0x34, 0x14, 0x15 with 1-bit stop → three `rxValid` pulses in order with matching data, each 640 cycles apart.
- `HRESET` for 1 cycle during bit 4 of a frame → all outputs 0 the next cycle, no strobe for the aborted frame; next complete frame 0x16 received correctly.
- Sender clock ±3% off nominal, 0x00 and 0xFF → both received, no `frameErr`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants.
// Used by both the receive and transmit sides of the AHB UART.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Oversample ticks per bit period.
    localparam int OVERSAMPLE = 16;

    // Tick index (within the current bit) at which the start bit is checked.
    localparam logic [3:0] MID_START = 4'd7;

    // Tick index at which data and stop bits are sampled. The count restarts
    // at mid start bit, so index 15 lands one full bit period later, at mid-bit.
    localparam logic [3:0] MID_BIT = 4'd15;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every TICK_DIV clocks.
// clr holds the divider at zero so ticks restart in phase with an event.
module uart_baud_tick #(
    parameter int TICK_DIV = 163
) (
    input  logic HCLK,
    input  logic HRESET,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next divider value: wrap on terminal count, hold at zero while cleared.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == TERM)) begin
            cnt_d = '0;
        end
    end

    // Divider register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == TERM) && !clr;

endmodule

// File: rtl/uart_rx_deserialiser.sv
// UART receive front-end: synchronises serialRx, detects start edges with
// 16x oversampling, samples 8N1 frames LSB-first at mid-bit and emits each
// byte as a one-cycle rxValid strobe (or a frameErr strobe on a low stop bit).
module uart_rx_deserialiser
    import uart_pkg::*;
#(
    parameter int TICK_DIV = 163
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       serialRx,
    output logic [7:0] rxData,
    output logic       rxValid,
    output logic       frameErr,
    output logic       busy
);

    logic        sync1_q;
    logic        rxS_q;
    logic        rxPrev_q;
    uart_state_e state_q,    state_d;
    logic [3:0]  sampCnt_q,  sampCnt_d;
    logic [2:0]  bitCnt_q,   bitCnt_d;
    logic [7:0]  shift_q,    shift_d;
    logic [7:0]  rxData_q,   rxData_d;
    logic        rxValid_q,  rxValid_d;
    logic        frameErr_q, frameErr_d;
    logic        tick;
    logic        tickClr;
    logic        fallEdge;

    // Divider sits at zero throughout IDLE, so the first tick after leaving
    // IDLE is exactly TICK_DIV cycles after the start edge was seen.
    assign tickClr = (state_q == IDLE);

    uart_baud_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_baud_tick (
        .HCLK  (HCLK),
        .HRESET(HRESET),
        .clr   (tickClr),
        .tick  (tick)
    );

    // Edge detect on the synchronised line; a held-low line never retriggers.
    assign fallEdge = rxPrev_q && !rxS_q;

    // Two-flop synchroniser plus one delayed copy for edge detection; idle high.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sync1_q  <= 1'b1;
            rxS_q    <= 1'b1;
            rxPrev_q <= 1'b1;
        end else begin
            sync1_q  <= serialRx;
            rxS_q    <= sync1_q;
            rxPrev_q <= rxS_q;
        end
    end

    // Receive FSM next-state, counters, shift register and output strobes.
    always_comb begin
        state_d    = state_q;
        sampCnt_d  = sampCnt_q;
        bitCnt_d   = bitCnt_q;
        shift_d    = shift_q;
        rxData_d   = rxData_q;
        rxValid_d  = 1'b0;
        frameErr_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (fallEdge) begin
                    state_d   = START;
                    sampCnt_d = '0;
                end
            end
            START: begin
                if (tick) begin
                    sampCnt_d = sampCnt_q + 4'd1;
                    if (sampCnt_q == MID_START) begin
                        // Restart bit timing at mid start bit; a high line here
                        // means the edge was a glitch.
                        sampCnt_d = '0;
                        if (!rxS_q) begin
                            state_d  = DATA;
                            bitCnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    sampCnt_d = sampCnt_q + 4'd1;
                    if (sampCnt_q == MID_BIT) begin
                        shift_d  = {rxS_q, shift_q[7:1]};
                        bitCnt_d = bitCnt_q + 3'd1;
                        if (bitCnt_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    sampCnt_d = sampCnt_q + 4'd1;
                    if (sampCnt_q == MID_BIT) begin
                        // Back to IDLE half a bit early so a following start
                        // edge right after a 1-bit stop is not missed.
                        state_d = IDLE;
                        if (rxS_q) begin
                            rxData_d  = shift_q;
                            rxValid_d = 1'b1;
                        end else begin
                            frameErr_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state, counters and output registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= IDLE;
            sampCnt_q  <= '0;
            bitCnt_q   <= '0;
            rxData_q   <= '0;
            rxValid_q  <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sampCnt_q  <= sampCnt_d;
            bitCnt_q   <= bitCnt_d;
            rxData_q   <= rxData_d;
            rxValid_q  <= rxValid_d;
            frameErr_q <= frameErr_d;
        end
    end

    // Shift register holds only in-flight data; it is fully overwritten by
    // eight samples before it is ever copied to rxData.
    always_ff @(posedge HCLK) begin
        shift_q <= shift_d;
    end

    assign rxData   = rxData_q;
    assign rxValid  = rxValid_q;
    assign frameErr = frameErr_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deserialiser.sv
// Bench for uart_rx_deserialiser: drives 8N1 frames and compares every output
// strobe against a queue of expected frames built by the sending task.
module tb_uart_rx_deserialiser;

    localparam int TD = 4;
    localparam int BP = 16 * TD;
    // Strobe expected about 9.5 bit periods after the pin's start edge.
    localparam int LAT_MIN = (BP * 19) / 2 - 3;
    localparam int LAT_MAX = (BP * 19) / 2 + 8;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic       serialRx;
    logic [7:0] rxData;
    logic       rxValid;
    logic       frameErr;
    logic       busy;

    uart_rx_deserialiser #(
        .TICK_DIV(TD)
    ) dut (
        .HCLK    (HCLK),
        .HRESET  (HRESET),
        .serialRx(serialRx),
        .rxData  (rxData),
        .rxValid (rxValid),
        .frameErr(frameErr),
        .busy    (busy)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [7:0] data;
        bit         good;
        int         t0;
    } frame_t;

    frame_t     expq[$];
    int         strobeCyc[$];
    logic [7:0] modelData = 8'h00;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         nValid = 0;
    int         nErr = 0;
    bit         monOn = 1'b0;
    bit         busyPrev = 1'b0;

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: every cycle, outputs against the expected-frame queue.
    always @(negedge HCLK) begin
        if (HRESET) begin
            modelData = 8'h00;
            busyPrev  = 1'b0;
        end else if (monOn) begin
            check("strobe_mutex", {31'd0, rxValid & frameErr}, 32'd0);
            if (rxValid || frameErr) begin
                if (expq.size() == 0) begin
                    check("unexpected_strobe", {30'd0, rxValid, frameErr}, 32'd0);
                end else begin
                    frame_t f;
                    int lat;
                    f = expq.pop_front();
                    lat = cyc - f.t0;
                    check("rxValid_kind", {31'd0, rxValid}, {31'd0, f.good});
                    check("frameErr_kind", {31'd0, frameErr}, {31'd0, !f.good});
                    check("latency_window", {31'd0, (lat >= LAT_MIN) && (lat <= LAT_MAX)}, 32'd1);
                    check("busy_low_at_strobe", {31'd0, busy}, 32'd0);
                    check("busy_high_before_strobe", {31'd0, busyPrev}, 32'd1);
                    if (f.good) modelData = f.data;
                    strobeCyc.push_back(cyc);
                end
                if (rxValid) nValid++;
                if (frameErr) nErr++;
            end
            check("rxData_hold", {24'd0, rxData}, {24'd0, modelData});
            busyPrev = busy;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop, input int bp);
        expq.push_back('{data: d, good: stop, t0: cyc});
        serialRx = 1'b0;
        step(bp);
        for (int i = 0; i < 8; i++) begin
            serialRx = d[i];
            step(bp);
        end
        serialRx = stop;
        step(bp);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (expq.size() != 0 && n < 2000) begin
            step(1);
            n++;
        end
        check(name, expq.size(), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0, e0, s0;
        bit seen;
        HRESET   = 1'b1;
        serialRx = 1'b1;
        step(3);
        check("reset_rxData", {24'd0, rxData}, 32'd0);
        check("reset_rxValid", {31'd0, rxValid}, 32'd0);
        check("reset_frameErr", {31'd0, frameErr}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        HRESET = 1'b0;
        step(1);
        monOn = 1'b1;
        step(20);

        // Single good byte.
        v0 = nValid; e0 = nErr;
        send_frame(8'h65, 1'b1, BP);
        wait_drain("drain_65");
        check("lit_65_data", {24'd0, rxData}, 32'h65);
        check("lit_65_one_valid", nValid - v0, 32'd1);
        check("lit_65_no_err", nErr - e0, 32'd0);
        step(BP);

        // 20-cycle low glitch: busy pulses, drops after mid-start check.
        v0 = nValid; e0 = nErr;
        serialRx = 1'b0;
        step(20);
        serialRx = 1'b1;
        step(10);
        check("glitch_busy_mid", {31'd0, busy}, 32'd1);
        step(10);
        check("glitch_busy_dropped", {31'd0, busy}, 32'd0);
        step(2 * BP);
        check("glitch_no_strobe", (nValid - v0) + (nErr - e0), 32'd0);

        // Framing error followed by a 5-bit-period break.
        v0 = nValid; e0 = nErr;
        send_frame(8'hA7, 1'b0, BP);
        wait_drain("drain_A7");
        seen = 1'b0;
        for (int i = 0; i < 5 * BP; i++) begin
            step(1);
            if (busy) seen = 1'b1;
        end
        check("break_no_busy", {31'd0, seen}, 32'd0);
        check("lit_err_count", nErr - e0, 32'd1);
        check("lit_err_no_valid", nValid - v0, 32'd0);
        check("lit_err_rxData_kept", {24'd0, rxData}, 32'h65);
        serialRx = 1'b1;
        step(2 * BP);
        send_frame(8'h5A, 1'b1, BP);
        wait_drain("drain_5A");
        check("lit_recover_data", {24'd0, rxData}, 32'h5A);
        step(BP);

        // Back-to-back frames with 1-bit stop.
        s0 = strobeCyc.size();
        send_frame(8'h34, 1'b1, BP);
        send_frame(8'h14, 1'b1, BP);
        send_frame(8'h15, 1'b1, BP);
        wait_drain("drain_b2b");
        check("b2b_count", strobeCyc.size() - s0, 32'd3);
        if (strobeCyc.size() - s0 == 3) begin
            check("b2b_gap1", strobeCyc[s0 + 1] - strobeCyc[s0], 32'd640);
            check("b2b_gap2", strobeCyc[s0 + 2] - strobeCyc[s0 + 1], 32'd640);
        end
        check("lit_b2b_last", {24'd0, rxData}, 32'h15);
        step(BP);

        // Reset in the middle of bit 4 of 0x3C (bit 4 is 1, so line stays high).
        v0 = nValid; e0 = nErr;
        serialRx = 1'b0;
        step(BP);
        for (int i = 0; i < 4; i++) begin
            serialRx = (8'h3C >> i) & 8'h01;
            step(BP);
        end
        serialRx = 1'b1;
        step(BP / 2);
        HRESET = 1'b1;
        step(1);
        HRESET = 1'b0;
        check("midreset_rxData", {24'd0, rxData}, 32'd0);
        check("midreset_rxValid", {31'd0, rxValid}, 32'd0);
        check("midreset_frameErr", {31'd0, frameErr}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        step(12 * BP);
        check("midreset_no_strobe", (nValid - v0) + (nErr - e0), 32'd0);
        send_frame(8'h16, 1'b1, BP);
        wait_drain("drain_16");
        check("lit_after_reset", {24'd0, rxData}, 32'h16);
        step(BP);

        // Sender clock about 3% slow and 3% fast.
        e0 = nErr;
        send_frame(8'h00, 1'b1, 66);
        wait_drain("drain_slow00");
        check("lit_slow00", {24'd0, rxData}, 32'h00);
        step(BP);
        send_frame(8'hFF, 1'b1, 62);
        wait_drain("drain_fastFF");
        check("lit_fastFF", {24'd0, rxData}, 32'hFF);
        check("baud_no_err", nErr - e0, 32'd0);
        step(BP);

        // Randomised frames, baud and gaps; occasional bad stop bit.
        for (int n = 0; n < 16; n++) begin
            logic [7:0] d;
            bit         good;
            int         bp;
            d    = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            bp   = $urandom_range(62, 66);
            send_frame(d, good, bp);
            serialRx = 1'b1;
            step(good ? $urandom_range(0, 40) : $urandom_range(4, 40));
        end
        wait_drain("drain_random");
        step(2 * BP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
